ahb_arbiter: RTL



---
 rtl/ahb_arbiter_if.sv | 49 ++++
 rtl/ahb_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_if
// Signals exchanged between the two AHB masters, the bus fabric and the
// arbiter.
//   HBUSREQ_M1/M2   bus request from M1 / M2
//   HLOCK_M1/M2     locked-transfer request from M1 / M2
//   HBURST_M1/M2    burst type from M1 / M2 (3 bits)
//   HTRANS          transfer type of the owning master (IDLE/BUSY/NONSEQ/SEQ)
//   HREADY          bus-wide transfer-done
//   HGRANT_M1/M2    grant to M1 / M2
//   HMASTER         address-phase owner (1 = M1, 2 = M2, 0 = none)
//   HMASTLOCK       current address phase is locked
// Modports:
//   master - the requesting side (drives requests, receives grants)
//   slave  - the arbiter side (receives requests, drives grants)
// ---------------------------------------------------------------------------
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 4
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif

interface ahb_arbiter_if;
    logic                         HBUSREQ_M1;
    logic                         HBUSREQ_M2;
    logic                         HLOCK_M1;
    logic                         HLOCK_M2;
    logic [2:0]                   HBURST_M1;
    logic [2:0]                   HBURST_M2;
    logic [`AHB_TRANS_BITS-1:0]   HTRANS;
    logic                         HREADY;
    logic                         HGRANT_M1;
    logic                         HGRANT_M2;
    logic [`AHB_MASTER_BITS-1:0]  HMASTER;
    logic                         HMASTLOCK;

    modport master (
        output HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2,
        output HBURST_M1, HBURST_M2, HTRANS, HREADY,
        input  HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2,
        input  HBURST_M1, HBURST_M2, HTRANS, HREADY,
        output HGRANT_M1, HGRANT_M2, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Two-master AHB arbiter. Round-robin between M1 and M2, keeps the bus with
// a locked owner, and never hands the bus over inside a fixed-length burst.
// HMASTER / HMASTLOCK only move on HREADY so ownership changes on a bus-cycle
// boundary.
// Ports:
//   HCLK     in   bus clock
//   HRESETn  in   asynchronous active-low reset
//   bus      slave modport of ahb_arbiter_if (requests, locks, bursts,
//            HTRANS, HREADY in; HGRANT_M1/M2, HMASTER, HMASTLOCK out)
// ---------------------------------------------------------------------------
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 4
`endif
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif

module ahb_arbiter (
    input  logic         HCLK,
    input  logic         HRESETn,
    ahb_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M1   = 2'd1,
        OWN_M2   = 2'd2
    } owner_t;

    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_IDLE   = `AHB_TRANS_BITS'(0);
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_BUSY   = `AHB_TRANS_BITS'(1);
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_NONSEQ = `AHB_TRANS_BITS'(2);
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_SEQ    = `AHB_TRANS_BITS'(3);

    localparam logic [`AHB_MASTER_BITS-1:0] HM_NONE = `AHB_MASTER_BITS'(0);
    localparam logic [`AHB_MASTER_BITS-1:0] HM_M1   = `AHB_MASTER_BITS'(1);
    localparam logic [`AHB_MASTER_BITS-1:0] HM_M2   = `AHB_MASTER_BITS'(2);

    owner_t                       owner, owner_next;
    owner_t                       last, last_next;
    logic [4:0]                   burst_left, burst_left_next;
    logic [`AHB_MASTER_BITS-1:0]  hmaster;
    logic                         hmastlock;
    logic [2:0]                   burst_sel;
    logic                         owner_lock;
    logic                         arb_ok;

    // Addresses still to come after a NONSEQ of the given burst type.
    // SINGLE and INCR have no fixed tail.
    function automatic logic [4:0] burst_tail(input logic [2:0] hburst);
        case (hburst)
            3'b010, 3'b011: return 5'd3;
            3'b100, 3'b101: return 5'd7;
            3'b110, 3'b111: return 5'd15;
            default:        return 5'd0;
        endcase
    endfunction

    function automatic logic [`AHB_MASTER_BITS-1:0] owner_code(input owner_t o);
        case (o)
            OWN_M1:  return HM_M1;
            OWN_M2:  return HM_M2;
            default: return HM_NONE;
        endcase
    endfunction

    // Burst type comes from whichever master currently owns the address phase.
    always_comb begin
        burst_sel = 3'b000;
        if (hmaster == HM_M1)
            burst_sel = bus.HBURST_M1;
        else if (hmaster == HM_M2)
            burst_sel = bus.HBURST_M2;
    end

    always_comb begin
        burst_left_next = burst_left;
        if (bus.HREADY) begin
            case (bus.HTRANS)
                TRANS_IDLE:   burst_left_next = 5'd0;
                TRANS_BUSY:   burst_left_next = burst_left;
                TRANS_NONSEQ: burst_left_next = burst_tail(burst_sel);
                TRANS_SEQ:    if (burst_left != 5'd0) burst_left_next = burst_left - 5'd1;
                default:      burst_left_next = burst_left;
            endcase
        end
    end

    always_comb begin
        owner_lock = 1'b0;
        if (owner == OWN_M1)
            owner_lock = bus.HLOCK_M1;
        else if (owner == OWN_M2)
            owner_lock = bus.HLOCK_M2;
    end

    // The burst count is judged on its value after this edge's update: the
    // grant may move on the edge that accepts the second-to-last address, so
    // the new owner's HMASTER lands on the edge accepting the last one. This
    // also blocks arbitration on the edge that accepts a burst's NONSEQ.
    assign arb_ok = bus.HREADY && !owner_lock && (burst_left_next <= 5'd1);

    always_comb begin
        owner_next = owner;
        last_next  = last;
        if (arb_ok) begin
            case ({bus.HBUSREQ_M1, bus.HBUSREQ_M2})
                2'b10:   owner_next = OWN_M1;
                2'b01:   owner_next = OWN_M2;
                2'b11:   owner_next = (last == OWN_M1) ? OWN_M2 : OWN_M1;
                default: owner_next = OWN_NONE;
            endcase
        end
        if (owner_next != OWN_NONE)
            last_next = owner_next;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner      <= OWN_NONE;
            last       <= OWN_M2;
            burst_left <= 5'd0;
            hmaster    <= HM_NONE;
            hmastlock  <= 1'b0;
        end else begin
            owner      <= owner_next;
            last       <= last_next;
            burst_left <= burst_left_next;
            // Address-phase ownership follows the grant one bus cycle later.
            if (bus.HREADY) begin
                hmaster   <= owner_code(owner);
                hmastlock <= owner_lock;
            end
        end
    end

    assign bus.HGRANT_M1 = (owner == OWN_M1);
    assign bus.HGRANT_M2 = (owner == OWN_M2);
    assign bus.HMASTER   = hmaster;
    assign bus.HMASTLOCK = hmastlock;

endmodule
